branch_resolve_stage: RTL and testbench
=======================================

// Module: branch_resolve_stage
// PURPOSE
//  Receiving end of instruction fetch: IF/ID pipeline register plus branch resolution.
//  Latches {pc, instruction} from fetch and decodes B, BL, CBZ and B.cond in ID.
//  Holds the NZCV flag register and returns BrTaken/UncondBr/target to fetch.
//  Squashes the wrong-path instruction fetched behind a taken branch.
// PARAMETERS
//  ADDR_W  64  PC / target width
//  INSN_W  32  instruction width (fixed; LEGv8 encoding)
// PORTS
//  clk             in   1       single clock, rising edge
//  reset           in   1       asynchronous, active-high
//  stall           in   1       hazard stall: hold ID contents, suppress branch outputs
//  if_pc           in   64      PC of instruction presented by fetch
//  if_instruction  in   32      instruction presented by fetch
//  flags_we        in   1       EX-stage flag-setting op writes NZCV this cycle
//  flags_in        in   4       {N,Z,C,V} from EX ALU
//  cbz_value       in   64      forwarded value of Rt (id_instruction[4:0]) for CBZ
//  id_pc           out  64      registered PC in ID
//  id_instruction  out  32      registered instruction in ID (0 when bubble)
//  id_valid        out  1       ID holds a live instruction
//  UncondBr        out  1       1: target uses BrAddr26, 0: CondAddr19
//  BrTaken         out  1       redirect fetch to br_target next edge
//  br_target       out  64      id_pc + (sext(imm) << 2)
//  flags_q         out  4       architectural NZCV register
// BEHAVIOUR
//  Reset (async): id_pc=0, id_instruction=0, id_valid=0, flags_q=4'b0000.
//   Hence BrTaken=0, UncondBr=0 and br_target=0 while reset is held and after release.
//  IF/ID register, per edge, in priority order:
//   1. stall=1:    hold id_pc, id_instruction and id_valid.
//   2. BrTaken=1:  load bubble. id_valid=0, id_instruction=0, id_pc=if_pc.
//                  This squashes the fall-through fetch.
//   3. otherwise:  load if_pc and if_instruction; id_valid=1.
//  Decode applies only when id_valid=1:
//   B   [31:26]=000101      -> UncondBr=1, taken
//   BL  [31:26]=100101      -> UncondBr=1, taken (link write handled elsewhere)
//   CBZ [31:24]=10110100    -> UncondBr=0, taken iff cbz_value==0
//   B.cond [31:24]=01010100 -> UncondBr=0, taken iff cond([4:0] low nibble) holds
//   any other encoding (incl. BR) -> UncondBr=0, BrTaken=0
//  BrTaken = id_valid & ~stall & taken. It is combinational from ID state; latency 0 in ID.
//   Fetch redirects on the following edge, so the branch penalty is 1 bubble.
//  Flags for B.cond: when flags_we=1, evaluate with flags_in (bypass); otherwise use flags_q.
//  Flags register: flags_q <= flags_in when flags_we. Updates are independent of stall and flush.
//  Condition codes, evaluated with N,Z,C,V:
//   EQ=0 Z; NE=1 !Z; HS=2 C; LO=3 !C; MI=4 N; PL=5 !N; VS=6 V; VC=7 !V;
//   HI=8 C&!Z; LS=9 !(C&!Z); GE=A N==V; LT=B N!=V; GT=C !Z&(N==V); LE=D !GT; E/F always.
//  Target arithmetic:
//   UncondBr=1: sext64(instr[25:0])<<2, else sext64(instr[23:5])<<2.
//   Add to id_pc modulo 2^64; wrap-around is silent and no overflow is flagged.
//  Boundary cases:
//   - Taken branch while stall=1: BrTaken stays 0 and the branch resolves on the first unstalled cycle.
//   - Back-to-back branches: the second one is the squashed fetch and never takes effect.
//   - Branch arrives in ID as a bubble (id_valid=0): no decode.
//   - Reset mid-stall or mid-flush: all state is cleared immediately, with no wait for clk.
// STRUCTURE
//  Shared package branch_pkg holds:
//   - opcode constants OP_B, OP_BL, OP_CBZ, OP_BCOND;
//   - typedef enum logic[3:0] cond_e (EQ..AL);
//   - typedef struct nzcv_t.
//  Sub-module branch_cond_eval: combinational {cond_e, nzcv_t} -> taken.
//  The IF/ID register, flag register, decode and target adder live at top level.
// TESTING
//  1. Reset held 3 cycles with if_instruction=B #4. Required: id_valid=0, BrTaken=0 and flags_q=0
//     throughout, and no outputs change until release.
//  2. id_pc=0x100 with B #-2 (0x17FFFFFE). Required: BrTaken=1, UncondBr=1, br_target=0xF8.
//     Next edge: id_valid=0 (squash).
//  3. flags_we=1, flags_in=4'b0100, B.EQ #3 in ID at pc 0x40. Required: BrTaken=1 (bypass) and
//     br_target=0x4C. Repeat with B.NE and the same flags: BrTaken=0.
//  4. CBZ X1 #8 at pc 0x200. With cbz_value=0: BrTaken=1, UncondBr=0, target=0x220.
//     With cbz_value=5: BrTaken=0.
//  5. B.GE in ID with flags_q N=1,V=1 and stall=1 for 2 cycles. Required: BrTaken=0 and ID held.
//     Stall drops: BrTaken=1 for exactly one cycle.
//  6. id_pc=0xFFFFFFFFFFFFFFFC with B #2. Required: br_target=0x4 (wrap).
//     Also assert reset asynchronously mid-cycle: id_valid drops before the next clk edge.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings and types for ID-stage branch resolution:
// opcode constants, condition-code enum and the NZCV flag struct.
package branch_pkg;

    localparam int ADDR_W = 64;
    localparam int INSN_W = 32;

    localparam logic [5:0] OP_B     = 6'b000101;
    localparam logic [5:0] OP_BL    = 6'b100101;
    localparam logic [7:0] OP_CBZ   = 8'b10110100;
    localparam logic [7:0] OP_BCOND = 8'b01010100;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator: {cond, NZCV} -> condition holds.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    cond_e cond_s;
    nzcv_t flags_s;
    logic  ge_s;
    logic  gt_s;
    logic  hi_s;

    assign cond_s  = cond_e'(cond);
    assign flags_s = nzcv_t'(flags);
    assign ge_s    = (flags_s.n == flags_s.v);
    assign gt_s    = ~flags_s.z & ge_s;
    assign hi_s    = flags_s.c & ~flags_s.z;

    // Condition decode; 0xE and 0xF both mean "always".
    always_comb begin
        taken = 1'b0;
        case (cond_s)
            COND_EQ: taken = flags_s.z;
            COND_NE: taken = ~flags_s.z;
            COND_HS: taken = flags_s.c;
            COND_LO: taken = ~flags_s.c;
            COND_MI: taken = flags_s.n;
            COND_PL: taken = ~flags_s.n;
            COND_VS: taken = flags_s.v;
            COND_VC: taken = ~flags_s.v;
            COND_HI: taken = hi_s;
            COND_LS: taken = ~hi_s;
            COND_GE: taken = ge_s;
            COND_LT: taken = ~ge_s;
            COND_GT: taken = gt_s;
            COND_LE: taken = ~gt_s;
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_stage.sv
// IF/ID pipeline register with branch resolution (B, BL, CBZ, B.cond),
// NZCV flag register and wrong-path squash of the fetch behind a taken branch.
module branch_resolve_stage
    import branch_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int INSN_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INSN_W-1:0] if_instruction,
    input  logic              flags_we,
    input  logic [3:0]        flags_in,
    input  logic [ADDR_W-1:0] cbz_value,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INSN_W-1:0] id_instruction,
    output logic              id_valid,
    output logic              UncondBr,
    output logic              BrTaken,
    output logic [ADDR_W-1:0] br_target,
    output logic [3:0]        flags_q
);

    logic              cond_taken_s;
    logic              taken_s;
    logic              uncond_s;
    logic [3:0]        eval_flags_s;
    logic [ADDR_W-1:0] offset26_s;
    logic [ADDR_W-1:0] offset19_s;

    // A flag-setting op in EX this cycle is bypassed to the B.cond evaluation.
    assign eval_flags_s = flags_we ? flags_in : flags_q;

    branch_cond_eval u_cond (
        .cond  (id_instruction[3:0]),
        .flags (eval_flags_s),
        .taken (cond_taken_s)
    );

    assign offset26_s = {{(ADDR_W-28){id_instruction[25]}}, id_instruction[25:0], 2'b00};
    assign offset19_s = {{(ADDR_W-21){id_instruction[23]}}, id_instruction[23:5], 2'b00};

    // Branch decode; a bubble in ID never decodes as a branch.
    always_comb begin
        taken_s  = 1'b0;
        uncond_s = 1'b0;
        if (!id_valid) begin
            taken_s  = 1'b0;
            uncond_s = 1'b0;
        end else if ((id_instruction[31:26] == OP_B) || (id_instruction[31:26] == OP_BL)) begin
            taken_s  = 1'b1;
            uncond_s = 1'b1;
        end else if (id_instruction[31:24] == OP_CBZ) begin
            taken_s  = (cbz_value == {ADDR_W{1'b0}});
            uncond_s = 1'b0;
        end else if (id_instruction[31:24] == OP_BCOND) begin
            taken_s  = cond_taken_s;
            uncond_s = 1'b0;
        end else begin
            taken_s  = 1'b0;
            uncond_s = 1'b0;
        end
    end

    assign UncondBr  = uncond_s;
    assign BrTaken   = id_valid & ~stall & taken_s;
    // Modulo-2^ADDR_W add; wrap-around is intentional and unflagged.
    assign br_target = id_pc + (uncond_s ? offset26_s : offset19_s);

    // IF/ID register: stall holds, a taken branch squashes the fall-through fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_pc          <= {ADDR_W{1'b0}};
            id_instruction <= {INSN_W{1'b0}};
            id_valid       <= 1'b0;
        end else if (stall) begin
            id_pc          <= id_pc;
            id_instruction <= id_instruction;
            id_valid       <= id_valid;
        end else if (BrTaken) begin
            id_pc          <= if_pc;
            id_instruction <= {INSN_W{1'b0}};
            id_valid       <= 1'b0;
        end else begin
            id_pc          <= if_pc;
            id_instruction <= if_instruction;
            id_valid       <= 1'b1;
        end
    end

    // Architectural NZCV register, written regardless of stall or squash.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (flags_we) begin
            flags_q <= flags_in;
        end else begin
            flags_q <= flags_q;
        end
    end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Self-checking bench for branch_resolve_stage: per-scenario tasks, expected
// outputs queued at stimulus time and compared when the DUT is sampled.
module tb_branch_resolve_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [63:0] if_pc;
    logic [31:0] if_instruction;
    logic        flags_we;
    logic [3:0]  flags_in;
    logic [63:0] cbz_value;
    logic [63:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic        UncondBr;
    logic        BrTaken;
    logic [63:0] br_target;
    logic [3:0]  flags_q;

    // {flags_q, id_valid, BrTaken, UncondBr, br_target}
    typedef logic [70:0] exp_t;
    exp_t exp_q[$];
    exp_t got;
    exp_t e;
    logic [3:0] exp_flags;
    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h8B020020;

    branch_resolve_stage dut (
        .clk(clk), .reset(reset), .stall(stall),
        .if_pc(if_pc), .if_instruction(if_instruction),
        .flags_we(flags_we), .flags_in(flags_in), .cbz_value(cbz_value),
        .id_pc(id_pc), .id_instruction(id_instruction), .id_valid(id_valid),
        .UncondBr(UncondBr), .BrTaken(BrTaken), .br_target(br_target),
        .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    task automatic load(input logic [63:0] pc, input logic [31:0] insn);
        if_pc = pc;
        if_instruction = insn;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flags_we = 1'b1; flags_in = 4'b1111;
        cbz_value = 64'd0; if_pc = 64'h1000; if_instruction = 32'h14000004;
        exp_flags = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({4'b0000, 1'b0, 1'b0, 1'b0, 64'd0});
            @(posedge clk); #1;
            got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
            e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL reset_hold got=%h exp=%h", got, e); bad++; end
        end
        flags_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_uncond_squash();
        load(64'hFC, NOP);
        exp_q.push_back({exp_flags, 1'b1, 1'b1, 1'b1, 64'hF8});
        load(64'h100, 32'h17FFFFFE);
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL b_minus2 got=%h exp=%h", got, e); bad++; end
        exp_q.push_back({exp_flags, 1'b0, 1'b0, 1'b0, 64'h104});
        load(64'h104, NOP);
        got = {flags_q, id_valid, BrTaken, UncondBr, id_pc};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL squash got=%h exp=%h", got, e); bad++; end
    endtask

    task automatic test_bcond_bypass();
        load(64'h3C, NOP);
        load(64'h40, 32'h54000060);
        exp_q.push_back({exp_flags, 1'b1, 1'b1, 1'b0, 64'h4C});
        flags_we = 1'b1; flags_in = 4'b0100; #1;
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL beq_bypass got=%h exp=%h", got, e); bad++; end
        flags_we = 1'b0;
        load(64'h3C, NOP);
        load(64'h3C, NOP);
        load(64'h40, 32'h54000061);
        exp_q.push_back({exp_flags, 1'b1, 1'b0, 1'b0, 64'h4C});
        flags_we = 1'b1; flags_in = 4'b0100; #1;
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL bne_bypass got=%h exp=%h", got, e); bad++; end
        flags_we = 1'b0;
    endtask

    task automatic test_cbz();
        load(64'h1FC, NOP);
        cbz_value = 64'd5;
        load(64'h200, 32'hB4000101);
        exp_q.push_back({exp_flags, 1'b1, 1'b0, 1'b0, 64'h220});
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL cbz_nonzero got=%h exp=%h", got, e); bad++; end
        exp_q.push_back({exp_flags, 1'b1, 1'b1, 1'b0, 64'h220});
        cbz_value = 64'd0; #1;
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL cbz_zero got=%h exp=%h", got, e); bad++; end
        cbz_value = 64'd7;
    endtask

    task automatic test_stall();
        flags_we = 1'b1; flags_in = 4'b1001;
        load(64'h2FC, NOP);
        exp_flags = 4'b1001;
        flags_we = 1'b0; flags_in = 4'b0000;
        load(64'h2FC, NOP);
        load(64'h300, 32'h5400002A);
        stall = 1'b1; if_pc = 64'h999; if_instruction = NOP;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({exp_flags, 1'b1, 1'b0, 1'b0, 64'h304});
            if (i > 0) begin @(posedge clk); end
            #1;
            got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
            e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL stall_hold%0d got=%h exp=%h", i, got, e); bad++; end
        end
        exp_q.push_back({exp_flags, 1'b1, 1'b1, 1'b0, 64'h304});
        stall = 1'b0; #1;
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL stall_release got=%h exp=%h", got, e); bad++; end
        exp_q.push_back({exp_flags, 1'b0, 1'b0, 1'b0, 64'h999});
        @(posedge clk); #1;
        got = {flags_q, id_valid, BrTaken, UncondBr, id_pc};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL stall_one_shot got=%h exp=%h", got, e); bad++; end
    endtask

    task automatic test_back_to_back();
        load(64'h4FC, NOP);
        exp_q.push_back({exp_flags, 1'b1, 1'b1, 1'b1, 64'h510});
        load(64'h500, 32'h14000004);
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL b2b_first got=%h exp=%h", got, e); bad++; end
        exp_q.push_back({exp_flags, 1'b0, 1'b0, 1'b0, 64'h504});
        load(64'h504, 32'h17FFFFFE);
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL b2b_second got=%h exp=%h", got, e); bad++; end
        exp_q.push_back({exp_flags, 1'b1, 1'b0, 1'b0, 64'h510});
        load(64'h510, NOP);
        got = {flags_q, id_valid, BrTaken, UncondBr, id_pc};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL b2b_resume got=%h exp=%h", got, e); bad++; end
    endtask

    task automatic test_wrap_async_reset();
        load(64'hFFFFFFFFFFFFFFF8, NOP);
        exp_q.push_back({exp_flags, 1'b1, 1'b1, 1'b1, 64'h4});
        load(64'hFFFFFFFFFFFFFFFC, 32'h14000002);
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL wrap got=%h exp=%h", got, e); bad++; end
        exp_flags = 4'b0000;
        exp_q.push_back({4'b0000, 1'b0, 1'b0, 1'b0, 64'd0});
        #1 reset = 1'b1;
        #1;
        got = {flags_q, id_valid, BrTaken, UncondBr, br_target};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin $display("FAIL async_reset got=%h exp=%h", got, e); bad++; end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_uncond_squash();
        test_bcond_bypass();
        test_cbz();
        test_stall();
        test_back_to_back();
        test_wrap_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
